// File: rtl/fifo_drain_tx.sv
// fifo_drain_tx: pops one timestamp word at a time and sends it MSB byte first on a valid/ready byte stream.
// Latency: 3 cycles from a non-empty FIFO seen in IDLE to first tx_valid; WORD_BYTES+3 cycles/word minimum.
// Backpressure: tx_ready low stalls the current byte; no new pop until the word is fully sent. Option: HEADER_EN.
module fifo_drain_tx #(
    parameter int          DATA_WIDTH = 48,
    parameter int          WORD_BYTES = 6,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
    parameter int          CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  buf_empty,
    output logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  word_cnt
);

`ifdef HEADER_EN
    localparam bit HDR_EN = 1'b1;
`else
    localparam bit HDR_EN = 1'b0;
`endif

    localparam int                NXFER    = WORD_BYTES + (HDR_EN ? 1 : 0);
    localparam int                IDX_W    = $clog2(NXFER + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NXFER - 1);

    typedef enum logic [1:0] {IDLE, POP, LATCH, SEND} state_t;

    state_t                 state_q;
    logic                   rd_en_q;
    logic                   tx_valid_q;
    logic                   busy_q;
    logic [7:0]             tx_data_q;
    logic [DATA_WIDTH-1:0]  shreg_q;
    logic [DATA_WIDTH-1:0]  shreg_d;
    logic [IDX_W-1:0]       idx_q;
    logic [CNT_WIDTH-1:0]   word_cnt_q;
    logic [CNT_WIDTH-1:0]   word_cnt_d;

    // The shift register always holds the bytes still to be presented, next one in the top byte.
    assign shreg_d    = {shreg_q[DATA_WIDTH-9:0], 8'h00};
    assign word_cnt_d = word_cnt_q + CNT_WIDTH'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            rd_en_q    <= 1'b0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            tx_data_q  <= '0;
            shreg_q    <= '0;
            idx_q      <= '0;
            word_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable && !buf_empty) begin
                        state_q <= POP;
                        rd_en_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                POP: begin
                    rd_en_q <= 1'b0;
                    state_q <= LATCH;
                end
                LATCH: begin
                    idx_q      <= '0;
                    tx_valid_q <= 1'b1;
                    state_q    <= SEND;
                    if (HDR_EN) begin
                        tx_data_q <= SYNC_BYTE;
                        shreg_q   <= fifo_data;
                    end else begin
                        tx_data_q <= fifo_data[DATA_WIDTH-1 -: 8];
                        shreg_q   <= {fifo_data[DATA_WIDTH-9:0], 8'h00};
                    end
                end
                SEND: begin
                    if (tx_ready) begin
                        if (idx_q == LAST_IDX) begin
                            tx_valid_q <= 1'b0;
                            busy_q     <= 1'b0;
                            word_cnt_q <= word_cnt_d;
                            state_q    <= IDLE;
                        end else begin
                            idx_q     <= idx_q + IDX_W'(1);
                            tx_data_q <= shreg_q[DATA_WIDTH-1 -: 8];
                            shreg_q   <= shreg_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rd_en    = rd_en_q;
    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
    assign busy     = busy_q;
    assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_fifo_drain_tx.sv
// Bench for fifo_drain_tx: table of words/ready patterns, hand-written corner sequences, then random traffic
// checked against a byte-queue reference model (FIFO contents -> expected byte stream and word count).
module tb_fifo_drain_tx;

`ifdef HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    localparam int NB = 6 + HDR;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        buf_empty = 1'b1;
    logic        tx_ready = 1'b0;
    logic [47:0] fifo_data = '0;
    logic        rd_en;
    logic        tx_valid;
    logic        busy;
    logic [7:0]  tx_data;
    logic [15:0] word_cnt;

    fifo_drain_tx dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .buf_empty (buf_empty),
        .rd_en     (rd_en),
        .fifo_data (fifo_data),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] word;
        logic [15:0] pat;     // tx_ready for SEND cycle k is pat[k]
        int          cyc;     // SEND cycles without header
        int          cyc_h;   // SEND cycles with header
    } vec_t;

    typedef struct {
        logic [7:0] b;
        bit         last;
    } xb_t;

    vec_t        vt [5];
    logic [47:0] fq [$];
    xb_t         exp_q [$];
    int          nvec = 0;
    int          nerr = 0;
    logic [15:0] model_cnt = '0;
    bit          stall_q = 1'b0;
    logic [7:0]  stall_dat = '0;
    bit          xfer_seen = 1'b0;
    logic [7:0]  xfer_byte = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model and FIFO, evaluated mid-cycle: compare the stream, then serve pops.
    task automatic neg_step();
        logic [47:0] w;
        xb_t         e;
        xfer_seen = 1'b0;
        if (!rst) begin
            exp_q.delete();
            model_cnt = '0;
            stall_q   = 1'b0;
        end else begin
            check("word_cnt", 64'(word_cnt), 64'(model_cnt));
            if (stall_q) begin
                check("hold_valid", 64'(tx_valid), 64'(1));
                check("hold_data", 64'(tx_data), 64'(stall_dat));
            end
            if (tx_valid && tx_ready) begin
                xfer_seen = 1'b1;
                xfer_byte = tx_data;
                check("byte_pending", 64'(exp_q.size() > 0), 64'(1));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("tx_byte", 64'(tx_data), 64'(e.b));
                    if (e.last) model_cnt = model_cnt + 16'd1;
                end
            end
            stall_q   = tx_valid && !tx_ready;
            stall_dat = tx_data;
            if (rd_en) begin
                check("pop_nonempty", 64'(fq.size() > 0), 64'(1));
                check("pop_word_done", 64'(exp_q.size()), 64'(0));
                if (fq.size() > 0) begin
                    w = fq.pop_front();
                    fifo_data = w;
                    if (HDR == 1) exp_q.push_back('{8'hA5, 1'b0});
                    for (int i = 0; i < 6; i++) exp_q.push_back('{w[47-8*i -: 8], i == 5});
                end
            end
        end
        buf_empty = (fq.size() == 0);
    endtask

    task automatic tick();
        @(negedge clk);
        neg_step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int          lat;
        int          pulses;
        int          k;
        int          nb;
        logic [55:0] got;
        logic [55:0] expw;
        logic [15:0] c0;
        c0 = model_cnt;
        fq.push_back(v.word);
        tx_ready = 1'b1;
        lat = 0;
        pulses = 0;
        while (!tx_valid && lat < 20) begin
            tick();
            lat++;
            if (rd_en) pulses++;
        end
        check($sformatf("v%0d_latency", id), 64'(lat), 64'(3));
        check($sformatf("v%0d_busy_on", id), 64'(busy), 64'(1));
        k = 0;
        nb = 0;
        got = '0;
        while (tx_valid && k < 16) begin
            tx_ready = v.pat[k];
            tick();
            k++;
            if (rd_en) pulses++;
            if (xfer_seen) begin
                got = {got[47:0], xfer_byte};
                nb++;
            end
        end
        expw = (HDR == 1) ? {8'hA5, v.word} : {8'h00, v.word};
        check($sformatf("v%0d_bytes", id), 64'(got), 64'(expw));
        check($sformatf("v%0d_nbytes", id), 64'(nb), 64'(NB));
        check($sformatf("v%0d_cycles", id), 64'(k), 64'((HDR == 1) ? v.cyc_h : v.cyc));
        check($sformatf("v%0d_word_cnt", id), 64'(word_cnt), 64'(c0 + 16'd1));
        check($sformatf("v%0d_busy_off", id), 64'(busy), 64'(0));
        check($sformatf("v%0d_rd_pulses", id), 64'(pulses), 64'(1));
        tx_ready = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int          pulses;
        int          p0;
        int          p1;
        int          nv;
        int          nb;
        int          t;
        logic [15:0] c0;
        logic [63:0] r;

        vt[0] = '{48'h0123_4567_89AB, 16'hFFFF, 6, 7};
        vt[1] = '{48'h0123_4567_89AB, 16'hFF69, 10, 11};
        vt[2] = '{48'h0000_0000_0001, 16'hFFFF, 6, 7};
        vt[3] = '{48'hFFFF_FFFF_FFFF, 16'hAAAA, 12, 14};
        vt[4] = '{48'hDEAD_BEEF_CAFE, 16'hFFFE, 7, 8};

        // Reset state
        #2 rst = 1'b0;
        tick();
        tick();
        check("rst_tx_valid", 64'(tx_valid), 64'(0));
        check("rst_rd_en", 64'(rd_en), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_word_cnt", 64'(word_cnt), 64'(0));
        check("rst_tx_data", 64'(tx_data), 64'(0));
        rst = 1'b1;
        tick();

        enable = 1'b1;
        for (int i = 0; i < 5; i++) run_vec(i, vt[i]);

        // Two queued words: back-to-back pops spaced by one full word
        c0 = model_cnt;
        fq.push_back(48'h0000_0000_0001);
        fq.push_back(48'hFFFF_FFFF_FFFF);
        tx_ready = 1'b1;
        pulses = 0;
        p0 = 0;
        p1 = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (rd_en) begin
                pulses++;
                if (pulses == 1) p0 = i;
                else p1 = i;
            end
        end
        check("two_rd_pulses", 64'(pulses), 64'(2));
        check("two_pop_spacing", 64'(p1 - p0), 64'(NB + 3));
        check("two_word_cnt", 64'(word_cnt), 64'(c0 + 16'd2));
        check("two_idle_valid", 64'(tx_valid), 64'(0));

        // enable low with data waiting, then enable dropped mid-word
        enable = 1'b0;
        fq.push_back(48'h5555_AAAA_0FF0);
        pulses = 0;
        nv = 0;
        repeat (10) begin
            tick();
            if (rd_en) pulses++;
            if (tx_valid) nv++;
        end
        check("en0_rd_en", 64'(pulses), 64'(0));
        check("en0_tx_valid", 64'(nv), 64'(0));
        fq.push_back(48'h1234_5678_9ABC);
        enable = 1'b1;
        nb = 0;
        t = 0;
        while (t < 40 && !(nb > 0 && !tx_valid)) begin
            tick();
            t++;
            if (xfer_seen) begin
                nb++;
                if (nb == 3) enable = 1'b0;
            end
        end
        check("en_drop_bytes", 64'(nb), 64'(NB));
        pulses = 0;
        repeat (10) begin
            tick();
            if (rd_en) pulses++;
        end
        check("en_drop_no_pop", 64'(pulses), 64'(0));
        check("en_drop_busy", 64'(busy), 64'(0));

        // Reset in the middle of a word, then a fresh full word
        fq.push_back(48'h0F1E_2D3C_4B5A);
        enable = 1'b1;
        tx_ready = 1'b1;
        nb = 0;
        t = 0;
        while (nb < 2 && t < 30) begin
            tick();
            t++;
            if (xfer_seen) nb++;
        end
        check("mid_rst_pre_bytes", 64'(nb), 64'(2));
        rst = 1'b0;
        #1;
        check("mid_rst_tx_valid", 64'(tx_valid), 64'(0));
        check("mid_rst_word_cnt", 64'(word_cnt), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        tick();
        rst = 1'b1;
        nb = 0;
        t = 0;
        while (t < 40 && !(nb > 0 && !tx_valid)) begin
            tick();
            t++;
            if (xfer_seen) nb++;
        end
        check("post_rst_bytes", 64'(nb), 64'(NB));
        check("post_rst_word_cnt", 64'(word_cnt), 64'(1));

        // Random traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            tx_ready = ($urandom_range(3) != 0);
            enable   = ($urandom_range(7) != 0);
            if ($urandom_range(5) == 0 && fq.size() < 4) begin
                r = {$urandom(), $urandom()};
                fq.push_back(r[47:0]);
            end
            tick();
        end
        enable = 1'b1;
        tx_ready = 1'b1;
        t = 0;
        while (t < 300 && (fq.size() > 0 || busy)) begin
            tick();
            t++;
        end
        tick();
        check("drain_fifo_empty", 64'(fq.size()), 64'(0));
        check("drain_busy", 64'(busy), 64'(0));
        check("drain_bytes_left", 64'(exp_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/fifo_drain_tx.md
Name: fifo_drain_tx

Overview:
Reader side of the 48-bit TDC timestamp FIFO. Pops one word at a time, then serializes it MSB-byte-first onto an 8-bit valid/ready byte stream feeding the UART/host transmitter. It sits between the timestamp FIFO's read port and the byte transmitter. It never pops the FIFO until the previous word has been fully sent.

Parameters:
DATA_WIDTH, 48, FIFO word width; must equal 8*WORD_BYTES
WORD_BYTES, 6, bytes sent per word
SYNC_BYTE, 8'hA5, header byte value (used only with HEADER_EN)
CNT_WIDTH, 16, width of word_cnt

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset (rst=0 resets)
enable  input  1  1 = allowed to start popping new words
buf_empty  input  1  FIFO empty flag
rd_en  output  1  FIFO pop strobe, registered
fifo_data  input  DATA_WIDTH  FIFO read data; valid the cycle after rd_en is high
tx_data  output  8  byte to transmitter
tx_valid  output  1  tx_data valid
tx_ready  input  1  transmitter accepts byte this cycle
busy  output  1  high in any state other than IDLE
word_cnt  output  CNT_WIDTH  words fully sent since reset, wraps modulo 2^CNT_WIDTH

Behaviour:
- Reset (rst=0, async): state=IDLE; rd_en=0, tx_valid=0, tx_data=0, busy=0, word_cnt=0, shift register=0, byte index=0.
- FSM states: IDLE, POP, LATCH, SEND.
- IDLE: if enable=1 and buf_empty=0, go to POP next cycle. Otherwise stay.
- POP: rd_en=1 for exactly this one cycle. The FIFO updates its output at the end of the cycle. Next state is LATCH.
- LATCH: capture fifo_data into the shift register and set byte index=0. Next state is SEND with tx_valid=1 and tx_data=fifo_data[DATA_WIDTH-1:DATA_WIDTH-8].
- SEND: hold tx_valid=1.
  - tx_data must stay stable while tx_ready=0.
  - On each cycle where tx_valid and tx_ready are both high, one byte transfers. Shift left by 8 and present the next byte the following cycle; there is no bubble between bytes.
  - After byte WORD_BYTES-1 transfers: tx_valid goes to 0, word_cnt increments, and the FSM returns to IDLE.
- Latency: from buf_empty=0 seen in IDLE to first tx_valid is 3 cycles (IDLE→POP→LATCH→SEND). Minimum period per word is WORD_BYTES+3 cycles with tx_ready held high.
- rd_en is asserted only in POP, and only when buf_empty was 0 in the preceding IDLE cycle. The block never pops an empty FIFO and never pops while a word is in flight.
- enable dropping mid-word: the current word completes normally and no new pop follows. enable is sampled only in IDLE.
- buf_empty and fifo_data are ignored in SEND.
- tx_ready high while tx_valid=0 has no effect.
- word_cnt wraps from 2^CNT_WIDTH-1 to 0 with no flag.
- Reset asserted mid-word: everything clears immediately, and the partial word is lost. tx_valid drops asynchronously; the transmitter must tolerate this.

Optional Feature:
HEADER_EN
- Defined: each word is preceded by one SYNC_BYTE. After LATCH the first byte presented is SYNC_BYTE, which uses the same valid/ready rules, followed by the WORD_BYTES data bytes. A word is WORD_BYTES+1 transfers, and first-tx_valid latency is unchanged.
- Undefined: no header. Exactly WORD_BYTES transfers per word.

Test Plan:
1. Reset, then FIFO holds 48'h0123_4567_89AB, tx_ready=1, enable=1 → rd_en one pulse; bytes 01,23,45,67,89,AB on 6 consecutive cycles; word_cnt=1; busy low after.
2. Same word, tx_ready toggling 1,0,0,1,... → tx_data holds each byte while ready=0; order unchanged; no extra rd_en pulse.
3. Two words in FIFO (48'h1, 48'hFFFF_FFFF_FFFF), ready=1 → exactly 2 rd_en pulses, each after the prior word's last byte; 12 data bytes; word_cnt=2; buf_empty=1 after, and no pop follows.
4. enable=0 while FIFO non-empty → rd_en stays 0 and tx_valid stays 0. Drop enable during byte 3 of a word → all 6 bytes still sent, then idle.
5. rst=0 pulse during byte 2 → tx_valid=0, word_cnt=0 immediately. After release with FIFO non-empty, a fresh pop is followed by a full 6-byte sequence.
6. HEADER_EN defined, word 48'hDEAD_BEEF_CAFE → A5,DE,AD,BE,EF,CA,FE. Undefined → the same word without A5.
